rv32v_decode_unit: RTL and testbench
====================================

Name: rv32v_decode_unit

Overview:
- Decode stage of the RV32V vector pipeline, between fetch2 and execute.
- Decodes one 32-bit vector instruction per cycle: OP-V arithmetic, vector loads and vector stores.
- Selects operands from the vector register file, scalar sources or the immediate, and attaches the current vector CSR state.
- Registers the result into the decode/execute pipeline register under hazard-unit stall/flush control.

Parameters:
- XLEN, 32, scalar and element data width.
- VLENB, 16, vector register length in bytes (VLEN = 128).

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, synchronous, active-high (1 = reset).
- instr  in  32  instruction from fetch2.
- fault_insn  in  1  fetch access fault flag.
- mal_insn  in  1  fetch misaligned flag.
- eew_in  in  2  fetch-side EEW for loads/stores (SEW8/16/32 encoding).
- stall_dec  in  1  hazard unit: hold the decode/execute register.
- flush_dec  in  1  hazard unit: insert a bubble.
- vl  in  32  CSR vl.
- vstart  in  32  CSR vstart.
- vlenb  in  32  CSR vlenb.
- sew  in  2  CSR SEW.
- lmul  in  3  CSR LMUL.
- vill  in  1  CSR vill.
- vs1_data, vs2_data, vs3_data  in  32 each  register-file read data.
- vs1_mask, vs2_mask, vs3_mask  in  1 each  register-file mask bits.
- xs1, xs2  in  32 each  scalar register values.
- vs1_sel, vs2_sel, vs3_sel  out  5 each  combinational register-file read indices: instr[19:15], instr[24:20], instr[11:7].
- scalar_hazard  out  1  combinational; 1 when the instruction reads xs1 or xs2 (OPIVX, OPMVX, vsetvl*, load/store base address).
- ex_valid  out  1  registered outputs below.
- ex_funct6  out  6
- ex_funct3  out  3
- ex_vd  out  5
- ex_vm  out  1
- ex_opa  out  32  operand A: vs1_data, xs1 or sign-extended simm5.
- ex_opb  out  32  vs2_data.
- ex_store_data  out  32  vs3_data.
- ex_mask  out  1  vs1_mask (v0 mask bit).
- ex_xs2  out  32  scalar stride / AVL.
- ex_is_load, ex_is_store, ex_is_cfg, ex_wen  out  1 each.
- ex_eew  out  2
- ex_sew  out  2
- ex_lmul  out  3
- ex_vl  out  32
- ex_vstart  out  32
- ex_widen  out  1
- ex_illegal  out  1
- ex_fault  out  1

Behaviour:
- Opcode 0x57 (OP-V) is decoded by funct3:
  - 000 OPIVV, 010 OPMVV: opa = vs1_data.
  - 011 OPIVI: opa = sign-extended rs1 field.
  - 100 OPIVX, 110 OPMVX: opa = xs1.
  - 111 OPCFG: ex_is_cfg = 1, no vector writeback.
  - 001 OPFVV and 101 OPFVF: illegal (no FP support).
- Opcode 0x07 is a vector load: ex_is_load = 1, ex_eew = eew_in, opa = xs1.
- Opcode 0x27 is a vector store: ex_is_store = 1, ex_eew = eew_in, opa = xs1.
- Any other opcode is illegal.
- ex_wen = 1 for non-cfg OP-V and for loads, when legal.
- For arithmetic ops, ex_eew = sew.
- Illegal also covers vill = 1 for any non-cfg vector op, and vstart >= vl for arithmetic ops.
- ex_fault = fault_insn | mal_insn; a faulting instruction forces ex_wen = 0.
- Pipeline register, 1-cycle latency:
  - Priority is reset > flush > stall > load.
  - Flush: ex_valid = 0 and all control bits (wen, load, store, cfg, illegal, fault) cleared.
  - Stall: all ex_* outputs hold their previous value.
  - Load: ex_valid = 1 and all fields captured.
- Simultaneous flush and stall: flush wins.
- Reset: every ex_* output is 0; ex_sew and ex_lmul reset to encoding 0.
- Mid-operation reset behaves identically to power-on reset.

Optional Feature:
- Macro RV32V_WIDEN_EN.
- Defined: OPMVV/OPMVX with funct6[5:4] = 11 are widening ops.
  - ex_widen = 1.
  - Illegal if sew = SEW32, or lmul = LMUL8, or vd overlaps the vs2 register group.
- Undefined: those encodings set ex_illegal = 1 and ex_widen = 0.

Decomposition:
- Shared package rv32i_types_pkg holds: opcode_t, vfunct3_t, vopi_t, vopm_t, the sew/lmul enums (SEW8/16/32, LMUL1/2/4/8), and the packed vopi/vopm instruction structs.
- One natural sub-module: rv32v_decode_ctrl, a combinational instruction-to-control decoder.
- The parent module keeps operand muxing and the pipeline register.

Test Plan:
- Reset with nRST = 1 for one cycle -> ex_valid = 0, ex_wen = 0, ex_opa = 0.
- Setup for the following cases: sew = SEW32, lmul = LMUL2, vl = 7, vs1_data = 0xA, vs2_data = 0xB, xs1 = 0xABCDABCD.
  - 0x022081D7 (vadd.vv v3,v2,v1) -> next cycle: ex_valid = 1, vd = 3, opa = 0xA, opb = 0xB, wen = 1, vl = 7.
  - 0x0220C1D7 (vadd.vx) -> opa = 0xABCDABCD, scalar_hazard = 1.
  - 0x022FB1D7 (vadd.vi, imm -1) -> opa = 0xFFFFFFFF.
- Stall asserted with a new instruction -> outputs unchanged; flush_dec = 1 -> ex_valid = 0, ex_wen = 0.
- Illegal and fault cases:
  - vill = 1 with vadd.vv -> ex_illegal = 1, ex_wen = 0.
  - Opcode 0x33 -> ex_illegal = 1.
  - fault_insn = 1 -> ex_fault = 1.
- 0xC220A1D7 (vwaddu.vv), sew = SEW16:
  - With RV32V_WIDEN_EN -> ex_widen = 1.
  - Without the macro, or with sew = SEW32 -> ex_illegal = 1.

Source files
------------

// File: rtl/rv32i_types_pkg.sv
// Shared RV32V decode types: opcode/funct enums, vtype encodings, instruction
// layouts and the decode/execute pipeline packet.
package rv32i_types_pkg;

    localparam int XLEN  = 32;
    localparam int VLENB = 16;

    typedef enum logic [6:0] {
        OP_V      = 7'h57,
        OP_VLOAD  = 7'h07,
        OP_VSTORE = 7'h27
    } opcode_t;

    typedef enum logic [2:0] {
        OPIVV = 3'b000,
        OPFVV = 3'b001,
        OPMVV = 3'b010,
        OPIVI = 3'b011,
        OPIVX = 3'b100,
        OPFVF = 3'b101,
        OPMVX = 3'b110,
        OPCFG = 3'b111
    } vfunct3_t;

    typedef enum logic [5:0] {
        VADD  = 6'b000000,
        VSUB  = 6'b000010,
        VRSUB = 6'b000011,
        VAND  = 6'b001001,
        VOR   = 6'b001010,
        VXOR  = 6'b001011
    } vopi_t;

    typedef enum logic [5:0] {
        VREDSUM = 6'b000000,
        VWADDU  = 6'b110000,
        VWADD   = 6'b110001,
        VWSUBU  = 6'b110010,
        VWSUB   = 6'b110011
    } vopm_t;

    typedef enum logic [1:0] {
        SEW8  = 2'b00,
        SEW16 = 2'b01,
        SEW32 = 2'b10
    } sew_t;

    typedef enum logic [2:0] {
        LMUL1 = 3'b000,
        LMUL2 = 3'b001,
        LMUL4 = 3'b010,
        LMUL8 = 3'b011
    } lmul_t;

    typedef enum logic [1:0] {
        OPA_VS1 = 2'b00,
        OPA_XS1 = 2'b01,
        OPA_IMM = 2'b10
    } opa_sel_t;

    typedef struct packed {
        vopi_t      funct6;
        logic       vm;
        logic [4:0] vs2;
        logic [4:0] vs1;
        vfunct3_t   funct3;
        logic [4:0] vd;
        opcode_t    opcode;
    } vopi_insn_t;

    typedef struct packed {
        vopm_t      funct6;
        logic       vm;
        logic [4:0] vs2;
        logic [4:0] vs1;
        vfunct3_t   funct3;
        logic [4:0] vd;
        opcode_t    opcode;
    } vopm_insn_t;

    typedef struct packed {
        logic            valid;
        logic [5:0]      funct6;
        logic [2:0]      funct3;
        logic [4:0]      vd;
        logic            vm;
        logic [XLEN-1:0] opa;
        logic [XLEN-1:0] opb;
        logic [XLEN-1:0] store_data;
        logic            mask;
        logic [XLEN-1:0] xs2;
        logic            is_load;
        logic            is_store;
        logic            is_cfg;
        logic            wen;
        logic [1:0]      eew;
        logic [1:0]      sew;
        logic [2:0]      lmul;
        logic [XLEN-1:0] vl;
        logic [XLEN-1:0] vstart;
        logic            widen;
        logic            illegal;
        logic            fault;
    } ex_pkt_t;

    // Registers in one LMUL group; fractional and reserved encodings occupy one.
    function automatic logic [3:0] lmul_regs(input logic [2:0] lmul);
        case (lmul)
            3'd1:    return 4'd2;
            3'd2:    return 4'd4;
            3'd3:    return 4'd8;
            default: return 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/rv32v_decode_ctrl.sv
// Combinational RV32V instruction-to-control decoder.
// Widening OPMVV/OPMVX support is enabled by defining RV32V_WIDEN_EN.
module rv32v_decode_ctrl
    import rv32i_types_pkg::*;
(
    input  logic [31:0] instr,
    input  logic        fault,
    input  logic [1:0]  eew_in,
    input  logic [1:0]  sew,
    input  logic [2:0]  lmul,
    input  logic        vill,
    input  logic [31:0] vl,
    input  logic [31:0] vstart,
    output logic        is_load,
    output logic        is_store,
    output logic        is_cfg,
    output logic        wen,
    output logic        widen,
    output logic        illegal,
    output logic        scalar_hazard,
    output logic [1:0]  eew,
    output logic [1:0]  opa_sel
);

    vopm_insn_t insn;
    opa_sel_t   sel;
    logic       arith;
    logic       widen_enc;
    logic       widen_bad;
    logic       unused_ok;

    assign insn      = vopm_insn_t'(instr);
    assign opa_sel   = sel;
    assign unused_ok = ^{instr, lmul};

`ifdef RV32V_WIDEN_EN
    logic [5:0] grp;
    logic [5:0] vd_ext;
    logic [5:0] vs2_ext;

    // The widened destination spans twice the source group size.
    always_comb begin
        grp       = 6'(lmul_regs(lmul));
        vd_ext    = {1'b0, insn.vd};
        vs2_ext   = {1'b0, insn.vs2};
        widen_bad = (sew == SEW32) || (lmul == LMUL8) ||
                    ((vd_ext < vs2_ext + grp) && (vs2_ext < vd_ext + (grp << 1)));
    end
`else
    assign widen_bad = 1'b1;
`endif

    always_comb begin
        is_load       = 1'b0;
        is_store      = 1'b0;
        is_cfg        = 1'b0;
        arith         = 1'b0;
        illegal       = 1'b0;
        scalar_hazard = 1'b0;
        sel           = OPA_VS1;
        eew           = sew;
        case (insn.opcode)
            OP_V: begin
                case (insn.funct3)
                    OPIVV, OPMVV: arith = 1'b1;
                    OPIVI: begin
                        arith = 1'b1;
                        sel   = OPA_IMM;
                    end
                    OPIVX, OPMVX: begin
                        arith         = 1'b1;
                        sel           = OPA_XS1;
                        scalar_hazard = 1'b1;
                    end
                    OPCFG: begin
                        is_cfg        = 1'b1;
                        sel           = OPA_XS1;
                        scalar_hazard = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_VLOAD: begin
                is_load       = 1'b1;
                sel           = OPA_XS1;
                eew           = eew_in;
                scalar_hazard = 1'b1;
            end
            OP_VSTORE: begin
                is_store      = 1'b1;
                sel           = OPA_XS1;
                eew           = eew_in;
                scalar_hazard = 1'b1;
            end
            default: illegal = 1'b1;
        endcase

        widen_enc = arith && (insn.funct3 == OPMVV || insn.funct3 == OPMVX) &&
                    (instr[31:30] == 2'b11);
`ifdef RV32V_WIDEN_EN
        widen = widen_enc;
`else
        widen = 1'b0;
`endif
        if ((arith || is_load || is_store) && vill)
            illegal = 1'b1;
        if (arith && (vstart >= vl))
            illegal = 1'b1;
        if (widen_enc && widen_bad)
            illegal = 1'b1;
        wen = (arith || is_load) && !illegal && !fault;
    end

endmodule

// File: rtl/rv32v_decode_unit.sv
// RV32V decode stage: operand selection and the decode/execute register.
// Optional widening-op decode is enabled by defining RV32V_WIDEN_EN.
module rv32v_decode_unit
    import rv32i_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] instr,
    input  logic        fault_insn,
    input  logic        mal_insn,
    input  logic [1:0]  eew_in,
    input  logic        stall_dec,
    input  logic        flush_dec,
    input  logic [31:0] vl,
    input  logic [31:0] vstart,
    input  logic [31:0] vlenb,
    input  logic [1:0]  sew,
    input  logic [2:0]  lmul,
    input  logic        vill,
    input  logic [31:0] vs1_data,
    input  logic [31:0] vs2_data,
    input  logic [31:0] vs3_data,
    input  logic        vs1_mask,
    input  logic        vs2_mask,
    input  logic        vs3_mask,
    input  logic [31:0] xs1,
    input  logic [31:0] xs2,
    output logic [4:0]  vs1_sel,
    output logic [4:0]  vs2_sel,
    output logic [4:0]  vs3_sel,
    output logic        scalar_hazard,
    output logic        ex_valid,
    output logic [5:0]  ex_funct6,
    output logic [2:0]  ex_funct3,
    output logic [4:0]  ex_vd,
    output logic        ex_vm,
    output logic [31:0] ex_opa,
    output logic [31:0] ex_opb,
    output logic [31:0] ex_store_data,
    output logic        ex_mask,
    output logic [31:0] ex_xs2,
    output logic        ex_is_load,
    output logic        ex_is_store,
    output logic        ex_is_cfg,
    output logic        ex_wen,
    output logic [1:0]  ex_eew,
    output logic [1:0]  ex_sew,
    output logic [2:0]  ex_lmul,
    output logic [31:0] ex_vl,
    output logic [31:0] ex_vstart,
    output logic        ex_widen,
    output logic        ex_illegal,
    output logic        ex_fault
);

    vopi_insn_t insn;
    logic       fault;
    logic       is_load, is_store, is_cfg, wen, widen, illegal;
    logic [1:0] eew;
    logic [1:0] opa_sel;
    logic [XLEN-1:0] opa;
    ex_pkt_t    next_pkt;
    ex_pkt_t    ex_q;
    logic       unused_ok;

    assign insn      = vopi_insn_t'(instr);
    assign vs1_sel   = instr[19:15];
    assign vs2_sel   = instr[24:20];
    assign vs3_sel   = instr[11:7];
    assign fault     = fault_insn | mal_insn;
    assign unused_ok = ^{vlenb, vs2_mask, vs3_mask, insn.vs2, insn.opcode} ^ (vlenb == 32'(VLENB));

    rv32v_decode_ctrl u_ctrl (
        .instr         (instr),
        .fault         (fault),
        .eew_in        (eew_in),
        .sew           (sew),
        .lmul          (lmul),
        .vill          (vill),
        .vl            (vl),
        .vstart        (vstart),
        .is_load       (is_load),
        .is_store      (is_store),
        .is_cfg        (is_cfg),
        .wen           (wen),
        .widen         (widen),
        .illegal       (illegal),
        .scalar_hazard (scalar_hazard),
        .eew           (eew),
        .opa_sel       (opa_sel)
    );

    always_comb begin
        case (opa_sel_t'(opa_sel))
            OPA_XS1: opa = xs1;
            OPA_IMM: opa = {{(XLEN-5){insn.vs1[4]}}, insn.vs1};
            default: opa = vs1_data;
        endcase
    end

    always_comb begin
        next_pkt            = '0;
        next_pkt.valid      = 1'b1;
        next_pkt.funct6     = insn.funct6;
        next_pkt.funct3     = insn.funct3;
        next_pkt.vd         = insn.vd;
        next_pkt.vm         = insn.vm;
        next_pkt.opa        = opa;
        next_pkt.opb        = vs2_data;
        next_pkt.store_data = vs3_data;
        next_pkt.mask       = vs1_mask;
        next_pkt.xs2        = xs2;
        next_pkt.is_load    = is_load;
        next_pkt.is_store   = is_store;
        next_pkt.is_cfg     = is_cfg;
        next_pkt.wen        = wen;
        next_pkt.eew        = eew;
        next_pkt.sew        = sew;
        next_pkt.lmul       = lmul;
        next_pkt.vl         = vl;
        next_pkt.vstart     = vstart;
        next_pkt.widen      = widen;
        next_pkt.illegal    = illegal;
        next_pkt.fault      = fault;
    end

    // A bubble only kills the control bits; operand fields are don't-care.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            ex_q <= '0;
        end else if (flush_dec) begin
            ex_q.valid    <= 1'b0;
            ex_q.wen      <= 1'b0;
            ex_q.is_load  <= 1'b0;
            ex_q.is_store <= 1'b0;
            ex_q.is_cfg   <= 1'b0;
            ex_q.illegal  <= 1'b0;
            ex_q.fault    <= 1'b0;
        end else if (!stall_dec) begin
            ex_q <= next_pkt;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_funct6     = ex_q.funct6;
    assign ex_funct3     = ex_q.funct3;
    assign ex_vd         = ex_q.vd;
    assign ex_vm         = ex_q.vm;
    assign ex_opa        = ex_q.opa;
    assign ex_opb        = ex_q.opb;
    assign ex_store_data = ex_q.store_data;
    assign ex_mask       = ex_q.mask;
    assign ex_xs2        = ex_q.xs2;
    assign ex_is_load    = ex_q.is_load;
    assign ex_is_store   = ex_q.is_store;
    assign ex_is_cfg     = ex_q.is_cfg;
    assign ex_wen        = ex_q.wen;
    assign ex_eew        = ex_q.eew;
    assign ex_sew        = ex_q.sew;
    assign ex_lmul       = ex_q.lmul;
    assign ex_vl         = ex_q.vl;
    assign ex_vstart     = ex_q.vstart;
    assign ex_widen      = ex_q.widen;
    assign ex_illegal    = ex_q.illegal;
    assign ex_fault      = ex_q.fault;

endmodule

// File: tb/tb_rv32v_decode_unit.sv
// Self-checking bench for rv32v_decode_unit: directed cases followed by
// randomized instructions compared against a behavioural decode model.
module tb_rv32v_decode_unit;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] instr = '0;
    logic        fault_insn = 1'b0, mal_insn = 1'b0;
    logic [1:0]  eew_in = '0;
    logic        stall_dec = 1'b0, flush_dec = 1'b0;
    logic [31:0] vl = '0, vstart = '0, vlenb = 32'd16;
    logic [1:0]  sew = '0;
    logic [2:0]  lmul = '0;
    logic        vill = 1'b0;
    logic [31:0] vs1_data = '0, vs2_data = '0, vs3_data = '0;
    logic        vs1_mask = 1'b0, vs2_mask = 1'b0, vs3_mask = 1'b0;
    logic [31:0] xs1 = '0, xs2 = '0;

    logic [4:0]  vs1_sel, vs2_sel, vs3_sel;
    logic        scalar_hazard;
    logic        ex_valid, ex_vm, ex_mask;
    logic [5:0]  ex_funct6;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_vd;
    logic [31:0] ex_opa, ex_opb, ex_store_data, ex_xs2, ex_vl, ex_vstart;
    logic        ex_is_load, ex_is_store, ex_is_cfg, ex_wen;
    logic [1:0]  ex_eew, ex_sew;
    logic [2:0]  ex_lmul;
    logic        ex_widen, ex_illegal, ex_fault;

    int nAsserts = 0;
    int nFails   = 0;

    typedef struct {
        logic        valid;
        logic [5:0]  funct6;
        logic [2:0]  funct3;
        logic [4:0]  vd;
        logic        vm;
        logic [31:0] opa, opb, store_data;
        logic        mask;
        logic [31:0] xs2;
        logic        is_load, is_store, is_cfg, wen;
        logic [1:0]  eew, sew;
        logic [2:0]  lmul;
        logic [31:0] vl, vstart;
        logic        widen, illegal, fault;
    } exp_t;

    exp_t expQ;

    rv32v_decode_unit dut (
        .CLK(CLK), .nRST(nRST), .instr(instr), .fault_insn(fault_insn),
        .mal_insn(mal_insn), .eew_in(eew_in), .stall_dec(stall_dec),
        .flush_dec(flush_dec), .vl(vl), .vstart(vstart), .vlenb(vlenb),
        .sew(sew), .lmul(lmul), .vill(vill), .vs1_data(vs1_data),
        .vs2_data(vs2_data), .vs3_data(vs3_data), .vs1_mask(vs1_mask),
        .vs2_mask(vs2_mask), .vs3_mask(vs3_mask), .xs1(xs1), .xs2(xs2),
        .vs1_sel(vs1_sel), .vs2_sel(vs2_sel), .vs3_sel(vs3_sel),
        .scalar_hazard(scalar_hazard), .ex_valid(ex_valid),
        .ex_funct6(ex_funct6), .ex_funct3(ex_funct3), .ex_vd(ex_vd),
        .ex_vm(ex_vm), .ex_opa(ex_opa), .ex_opb(ex_opb),
        .ex_store_data(ex_store_data), .ex_mask(ex_mask), .ex_xs2(ex_xs2),
        .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_is_cfg(ex_is_cfg), .ex_wen(ex_wen), .ex_eew(ex_eew),
        .ex_sew(ex_sew), .ex_lmul(ex_lmul), .ex_vl(ex_vl),
        .ex_vstart(ex_vstart), .ex_widen(ex_widen), .ex_illegal(ex_illegal),
        .ex_fault(ex_fault)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one instruction with hazard controls, clock it, settle past the edge.
    task automatic applyStimulus(input logic [31:0] newInstr, input logic doStall,
                                 input logic doFlush);
        instr     = newInstr;
        stall_dec = doStall;
        flush_dec = doFlush;
        @(posedge CLK);
        #1;
        stall_dec = 1'b0;
        flush_dec = 1'b0;
    endtask

    task automatic applyReset();
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        nRST = 1'b0;
    endtask

    // Decode as the instruction set describes it, from current bench inputs.
    function automatic exp_t modelDecode();
        exp_t e = '{default: '0};
        int op = int'(instr[6:0]);
        int f3 = int'(instr[14:12]);
        int imm = int'(instr[19:15]);
        int vd = int'(instr[11:7]);
        int vs2 = int'(instr[24:20]);
        bit isOpv = (op == 'h57);
        bit isMem = (op == 'h07) || (op == 'h27);
        bit isCfg = isOpv && f3 == 7;
        bit isFp = isOpv && (f3 == 1 || f3 == 5);
        bit isArith = isOpv && !isCfg && !isFp;
        bit wideEnc = isArith && (f3 == 2 || f3 == 6) && instr[31:30] == 2'b11;
        bit wideBad = 1'b1;
        if (imm >= 16) imm -= 32;
`ifdef RV32V_WIDEN_EN
        begin
            int n = (lmul < 4) ? (1 << lmul) : 1;
            bit overlap = 0;
            for (int r = 0; r < 64; r++)
                if (r >= vd && r < vd + 2 * n && r >= vs2 && r < vs2 + n) overlap = 1;
            wideBad = (sew == 2'd2) || (lmul == 3'd3) || overlap;
            e.widen = wideEnc;
        end
`endif
        e.valid      = 1'b1;
        e.funct6     = instr[31:26];
        e.funct3     = instr[14:12];
        e.vd         = instr[11:7];
        e.vm         = instr[25];
        if (isMem || (isOpv && (f3 == 4 || f3 == 6 || f3 == 7))) e.opa = xs1;
        else if (isOpv && f3 == 3) e.opa = imm;
        else e.opa = vs1_data;
        e.opb        = vs2_data;
        e.store_data = vs3_data;
        e.mask       = vs1_mask;
        e.xs2        = xs2;
        e.is_load    = (op == 'h07);
        e.is_store   = (op == 'h27);
        e.is_cfg     = isCfg;
        e.eew        = isMem ? eew_in : sew;
        e.sew        = sew;
        e.lmul       = lmul;
        e.vl         = vl;
        e.vstart     = vstart;
        e.fault      = fault_insn | mal_insn;
        e.illegal    = !(isOpv || isMem) || isFp || (vill && (isArith || isMem)) ||
                       (isArith && vstart >= vl) || (wideEnc && wideBad);
        e.wen        = (isArith || e.is_load) && !e.illegal && !e.fault;
        return e;
    endfunction

    function automatic logic expectHazard();
        int f3 = int'(instr[14:12]);
        return (instr[6:0] == 7'h07) || (instr[6:0] == 7'h27) ||
               (instr[6:0] == 7'h57 && (f3 == 4 || f3 == 6 || f3 == 7));
    endfunction

    task automatic checkAll(input string ctx, input exp_t e);
        checkOutput({ctx, ".valid"}, 32'(ex_valid), 32'(e.valid));
        checkOutput({ctx, ".funct6"}, 32'(ex_funct6), 32'(e.funct6));
        checkOutput({ctx, ".funct3"}, 32'(ex_funct3), 32'(e.funct3));
        checkOutput({ctx, ".vd"}, 32'(ex_vd), 32'(e.vd));
        checkOutput({ctx, ".vm"}, 32'(ex_vm), 32'(e.vm));
        checkOutput({ctx, ".opa"}, ex_opa, e.opa);
        checkOutput({ctx, ".opb"}, ex_opb, e.opb);
        checkOutput({ctx, ".store_data"}, ex_store_data, e.store_data);
        checkOutput({ctx, ".mask"}, 32'(ex_mask), 32'(e.mask));
        checkOutput({ctx, ".xs2"}, ex_xs2, e.xs2);
        checkOutput({ctx, ".is_load"}, 32'(ex_is_load), 32'(e.is_load));
        checkOutput({ctx, ".is_store"}, 32'(ex_is_store), 32'(e.is_store));
        checkOutput({ctx, ".is_cfg"}, 32'(ex_is_cfg), 32'(e.is_cfg));
        checkOutput({ctx, ".wen"}, 32'(ex_wen), 32'(e.wen));
        checkOutput({ctx, ".eew"}, 32'(ex_eew), 32'(e.eew));
        checkOutput({ctx, ".sew"}, 32'(ex_sew), 32'(e.sew));
        checkOutput({ctx, ".lmul"}, 32'(ex_lmul), 32'(e.lmul));
        checkOutput({ctx, ".vl"}, ex_vl, e.vl);
        checkOutput({ctx, ".vstart"}, ex_vstart, e.vstart);
        checkOutput({ctx, ".widen"}, 32'(ex_widen), 32'(e.widen));
        checkOutput({ctx, ".illegal"}, 32'(ex_illegal), 32'(e.illegal));
        checkOutput({ctx, ".fault"}, 32'(ex_fault), 32'(e.fault));
    endtask

    initial begin
        // Power-on reset with non-trivial inputs present.
        instr = 32'h022081D7;
        vs1_data = 32'h5; xs1 = 32'h77; sew = 2'd2; lmul = 3'd1; vl = 32'd3;
        applyReset();
        checkOutput("reset.valid", 32'(ex_valid), 32'd0);
        checkOutput("reset.wen", 32'(ex_wen), 32'd0);
        checkOutput("reset.opa", ex_opa, 32'd0);
        checkOutput("reset.sew", 32'(ex_sew), 32'd0);
        checkOutput("reset.lmul", 32'(ex_lmul), 32'd0);

        sew = 2'd2; lmul = 3'd1; vl = 32'd7; vstart = 32'd0;
        vs1_data = 32'hA; vs2_data = 32'hB; vs3_data = 32'hC; xs1 = 32'hABCDABCD; xs2 = 32'h40;

        applyStimulus(32'h022081D7, 1'b0, 1'b0);
        checkOutput("vv.valid", 32'(ex_valid), 32'd1);
        checkOutput("vv.vd", 32'(ex_vd), 32'd3);
        checkOutput("vv.opa", ex_opa, 32'hA);
        checkOutput("vv.opb", ex_opb, 32'hB);
        checkOutput("vv.wen", 32'(ex_wen), 32'd1);
        checkOutput("vv.vl", ex_vl, 32'd7);
        checkOutput("vv.eew", 32'(ex_eew), 32'd2);
        checkOutput("vv.hazard", 32'(scalar_hazard), 32'd0);
        checkOutput("vv.vs1_sel", 32'(vs1_sel), 32'd1);
        checkOutput("vv.vs2_sel", 32'(vs2_sel), 32'd2);
        checkOutput("vv.vs3_sel", 32'(vs3_sel), 32'd3);

        applyStimulus(32'h0220C1D7, 1'b0, 1'b0);
        checkOutput("vx.opa", ex_opa, 32'hABCDABCD);
        checkOutput("vx.hazard", 32'(scalar_hazard), 32'd1);

        applyStimulus(32'h022FB1D7, 1'b0, 1'b0);
        checkOutput("vi.opa", ex_opa, 32'hFFFFFFFF);
        checkOutput("vi.wen", 32'(ex_wen), 32'd1);

        applyStimulus(32'h0220C2D7, 1'b1, 1'b0);
        checkOutput("stall.vd", 32'(ex_vd), 32'd3);
        checkOutput("stall.opa", ex_opa, 32'hFFFFFFFF);
        checkOutput("stall.funct3", 32'(ex_funct3), 32'd3);

        applyStimulus(32'h022081D7, 1'b1, 1'b1);
        checkOutput("flush.valid", 32'(ex_valid), 32'd0);
        checkOutput("flush.wen", 32'(ex_wen), 32'd0);

        vill = 1'b1;
        applyStimulus(32'h022081D7, 1'b0, 1'b0);
        checkOutput("vill.illegal", 32'(ex_illegal), 32'd1);
        checkOutput("vill.wen", 32'(ex_wen), 32'd0);
        vill = 1'b0;

        applyStimulus(32'h00000033, 1'b0, 1'b0);
        checkOutput("opc33.illegal", 32'(ex_illegal), 32'd1);
        checkOutput("opc33.wen", 32'(ex_wen), 32'd0);

        fault_insn = 1'b1;
        applyStimulus(32'h022081D7, 1'b0, 1'b0);
        checkOutput("fault.fault", 32'(ex_fault), 32'd1);
        checkOutput("fault.wen", 32'(ex_wen), 32'd0);
        fault_insn = 1'b0;
        mal_insn = 1'b1;
        applyStimulus(32'h022081D7, 1'b0, 1'b0);
        checkOutput("mal.fault", 32'(ex_fault), 32'd1);
        mal_insn = 1'b0;

        vstart = 32'd7;
        applyStimulus(32'h022081D7, 1'b0, 1'b0);
        checkOutput("vstart_eq_vl.illegal", 32'(ex_illegal), 32'd1);
        vstart = 32'd6;
        applyStimulus(32'h022081D7, 1'b0, 1'b0);
        checkOutput("vstart_lt_vl.illegal", 32'(ex_illegal), 32'd0);
        checkOutput("vstart_lt_vl.wen", 32'(ex_wen), 32'd1);
        vstart = 32'd0;

        eew_in = 2'd1;
        applyStimulus(32'h02058187, 1'b0, 1'b0);
        checkOutput("load.is_load", 32'(ex_is_load), 32'd1);
        checkOutput("load.eew", 32'(ex_eew), 32'd1);
        checkOutput("load.opa", ex_opa, 32'hABCDABCD);
        checkOutput("load.wen", 32'(ex_wen), 32'd1);
        applyStimulus(32'h02058127, 1'b0, 1'b0);
        checkOutput("store.is_store", 32'(ex_is_store), 32'd1);
        checkOutput("store.wen", 32'(ex_wen), 32'd0);
        checkOutput("store.data", ex_store_data, 32'hC);

        sew = 2'd1; lmul = 3'd0;
        applyStimulus(32'hC220A1D7, 1'b0, 1'b0);
`ifdef RV32V_WIDEN_EN
        checkOutput("widen16.widen", 32'(ex_widen), 32'd1);
        checkOutput("widen16.illegal", 32'(ex_illegal), 32'd0);
`else
        checkOutput("widen16.widen", 32'(ex_widen), 32'd0);
        checkOutput("widen16.illegal", 32'(ex_illegal), 32'd1);
`endif
        sew = 2'd2;
        applyStimulus(32'hC220A1D7, 1'b0, 1'b0);
        checkOutput("widen32.illegal", 32'(ex_illegal), 32'd1);

        // Mid-run reset, then randomized traffic against the model.
        applyReset();
        expQ = '{default: '0};
        checkAll("midreset", expQ);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] r;
            int pick;
            logic st, fl;
            r = $urandom;
            pick = $urandom_range(0, 9);
            if (pick <= 5) r[6:0] = 7'h57;
            else if (pick == 6) r[6:0] = 7'h07;
            else if (pick == 7) r[6:0] = 7'h27;
            else if (pick == 8) r[6:0] = 7'h33;
            fault_insn = ($urandom_range(0, 9) == 0);
            mal_insn   = ($urandom_range(0, 14) == 0);
            eew_in     = 2'($urandom_range(0, 2));
            sew        = 2'($urandom_range(0, 2));
            lmul       = 3'($urandom_range(0, 7));
            vill       = ($urandom_range(0, 9) == 0);
            vl         = 32'($urandom_range(0, 8));
            vstart     = 32'($urandom_range(0, 3));
            vs1_data   = $urandom; vs2_data = $urandom; vs3_data = $urandom;
            vs1_mask   = 1'($urandom); xs1 = $urandom; xs2 = $urandom;
            st = ($urandom_range(0, 6) == 0);
            fl = ($urandom_range(0, 9) == 0);
            instr = r;
            if (fl) begin
                expQ.valid = 0; expQ.wen = 0; expQ.is_load = 0; expQ.is_store = 0;
                expQ.is_cfg = 0; expQ.illegal = 0; expQ.fault = 0;
            end else if (!st) begin
                expQ = modelDecode();
            end
            applyStimulus(r, st, fl);
            checkOutput("rand.hazard", 32'(scalar_hazard), 32'(expectHazard()));
            checkOutput("rand.vs1_sel", 32'(vs1_sel), 32'(r[19:15]));
            checkAll("rand", expQ);
        end

        applyReset();
        checkOutput("finalreset.valid", 32'(ex_valid), 32'd0);
        checkOutput("finalreset.opa", ex_opa, 32'd0);
        checkOutput("finalreset.illegal", 32'(ex_illegal), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
